// File: rtl/dff_bank_pkg.sv
// dff_bank_pkg
//   Shared types for the dff_bank_n_m register bank.
//   state_e : controller state (IDLE, SHIFT).
//   op_e    : per-entry operation chosen by the controller each cycle.
package dff_bank_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_SHIFT = 2'd2,
        OP_CLEAR = 2'd3
    } op_e;

endpackage

// File: rtl/dff_bank_lane.sv
// dff_bank_lane
//   One N-bit entry of the bank. Each cycle it holds, loads its parallel
//   word, takes its left neighbour (shift) or returns to RST_VAL, as told
//   by the operation code. Reset has priority over every operation.
// Ports:
//   i_clk      clock
//   i_rst      synchronous active-high reset
//   i_op       operation for this cycle (op_e)
//   i_load_d   parallel load word for this entry
//   i_shift_d  word from the left neighbour (or the shift input for entry 0)
//   o_q        registered entry contents
module dff_bank_lane
    import dff_bank_pkg::*;
#(
    parameter int             N       = 4,
    parameter logic [N-1:0]   RST_VAL = '0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  op_e           i_op,
    input  logic [N-1:0]  i_load_d,
    input  logic [N-1:0]  i_shift_d,
    output logic [N-1:0]  o_q
);

    logic [N-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= RST_VAL;
        end else begin
            case (i_op)
                OP_LOAD:  r_q <= i_load_d;
                OP_SHIFT: r_q <= i_shift_d;
                OP_CLEAR: r_q <= RST_VAL;
                default:  r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/dff_bank_n_m.sv
// dff_bank_n_m
//   Bank of M+1 registers, N bits each, all resetting to RST_VAL.
//   Supports per-entry masked load, synchronous clear and, when the macro
//   DFF_BANK_SHIFT_EN is defined, a counted shift (delay-line) sequence
//   run by a two-state controller with busy/done status. Without the macro
//   the shift inputs are ignored and busy_o/done_o are tied low.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset
//   in_i        parallel load data, one word per entry
//   ld_i        per-entry load mask (bit k enables entry k)
//   clr_i       synchronous clear (aborts a shift, no done pulse)
//   sh_start_i  start a shift sequence (IDLE only)
//   sh_cnt_i    number of shift steps, sampled with sh_start_i
//   sh_in_i     word shifted into entry 0 on each step
//   out_o       registered bank contents
//   busy_o      high while the controller is in SHIFT
//   done_o      one-cycle pulse after the final shift step
// Handshake: sh_start_i is a single-cycle request, accepted only while
//   busy_o is low (including the cycle done_o is high); it is ignored
//   while busy_o is high. No backpressure is exposed.
module dff_bank_n_m
    import dff_bank_pkg::*;
#(
    parameter int N       = 4,
    parameter int M       = 15,
    parameter int RST_VAL = 0,
    parameter int SHW     = $clog2(M + 2)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [N-1:0]   in_i [0:M],
    input  logic [M:0]     ld_i,
    input  logic           clr_i,
    input  logic           sh_start_i,
    input  logic [SHW-1:0] sh_cnt_i,
    input  logic [N-1:0]   sh_in_i,
    output logic [N-1:0]   out_o [0:M],
    output logic           busy_o,
    output logic           done_o
);

    localparam logic [N-1:0] LP_RST_VAL = RST_VAL[N-1:0];

    // Bank-wide decisions made by the controller each cycle.
    logic w_do_shift;
    logic w_load_en;

`ifdef DFF_BANK_SHIFT_EN
    state_e         r_state, w_state_nxt;
    logic [SHW-1:0] r_cnt,   w_cnt_nxt;
    logic           r_done,  w_done_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Priority: clear > active shift step > start > load.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_do_shift  = 1'b0;
        w_load_en   = 1'b0;
        if (clr_i) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else if (r_state == ST_SHIFT) begin
            w_do_shift = 1'b1;
            w_cnt_nxt  = r_cnt - SHW'(1);
            if (r_cnt == SHW'(1)) begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end
        end else if (sh_start_i) begin
            // The start cycle itself moves no data; a zero count only
            // produces the done pulse.
            if (sh_cnt_i != '0) begin
                w_state_nxt = ST_SHIFT;
                w_cnt_nxt   = sh_cnt_i;
            end else begin
                w_done_nxt = 1'b1;
            end
        end else begin
            w_load_en = 1'b1;
        end
    end

    assign busy_o = (r_state == ST_SHIFT);
    assign done_o = r_done;
`else
    logic w_unused_sh;

    assign w_do_shift  = 1'b0;
    assign w_load_en   = 1'b1;
    assign busy_o      = 1'b0;
    assign done_o      = 1'b0;
    assign w_unused_sh = sh_start_i ^ (^sh_cnt_i);
`endif

    for (genvar k = 0; k <= M; k++) begin : g_lane
        op_e          w_op;
        logic [N-1:0] w_shift_d;

        if (k == 0) begin : g_head
            assign w_shift_d = sh_in_i;
        end else begin : g_body
            assign w_shift_d = out_o[k-1];
        end

        assign w_op = clr_i                   ? OP_CLEAR :
                      w_do_shift              ? OP_SHIFT :
                      (w_load_en && ld_i[k])  ? OP_LOAD  : OP_HOLD;

        dff_bank_lane #(
            .N       (N),
            .RST_VAL (LP_RST_VAL)
        ) u_lane (
            .i_clk     (clk_i),
            .i_rst     (rst_i),
            .i_op      (w_op),
            .i_load_d  (in_i[k]),
            .i_shift_d (w_shift_d),
            .o_q       (out_o[k])
        );
    end

endmodule

// File: tb/tb_dff_bank_n_m.sv
module tb_dff_bank_n_m;

  localparam int N   = 4;
  localparam int M   = 3;
  localparam int RV  = 5;
  localparam int SHW = $clog2(M + 2);

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   in_i [0:M];
  logic [M:0]     ld;
  logic           clr;
  logic           sh_start;
  logic [SHW-1:0] sh_cnt;
  logic [N-1:0]   sh_in;
  logic [N-1:0]   out_o [0:M];
  logic           busy;
  logic           done;
  logic [15:0]    obs;

  int n_checks = 0;
  int n_fail   = 0;

  assign obs = {out_o[0], out_o[1], out_o[2], out_o[3]};

  dff_bank_n_m #(.N(N), .M(M), .RST_VAL(RV), .SHW(SHW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_i       (in_i),
    .ld_i       (ld),
    .clr_i      (clr),
    .sh_start_i (sh_start),
    .sh_cnt_i   (sh_cnt),
    .sh_in_i    (sh_in),
    .out_o      (out_o),
    .busy_o     (busy),
    .done_o     (done)
  );

  // driver tasks: inputs change on the falling edge, outputs are sampled there too
  task automatic tick();
    @(negedge clk);
  endtask

  // v = {entry0, entry1, entry2, entry3}
  task automatic set_in(input logic [15:0] v);
    in_i[0] = v[15:12];
    in_i[1] = v[11:8];
    in_i[2] = v[7:4];
    in_i[3] = v[3:0];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (obs !== 16'h5555) begin n_fail++; $display("FAIL reset_out: got %h want %h", obs, 16'h5555); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
  endtask

  task automatic test_load();
    set_in(16'h1234); ld = 4'b0101;
    tick();
    ld = 4'b0000;
    n_checks++; if (obs !== 16'h1535) begin n_fail++; $display("FAIL load_mask: got %h want %h", obs, 16'h1535); end
    set_in(16'hFFFF);
    tick();
    n_checks++; if (obs !== 16'h1535) begin n_fail++; $display("FAIL load_hold: got %h want %h", obs, 16'h1535); end
    set_in(16'h1234); ld = 4'b1111;
    tick();
    ld = 4'b0000;
    n_checks++; if (obs !== 16'h1234) begin n_fail++; $display("FAIL load_all: got %h want %h", obs, 16'h1234); end
  endtask

  task automatic test_clear_idle();
    // clear outranks a simultaneous full load
    set_in(16'hABCD); ld = 4'b1111; clr = 1'b1;
    tick();
    clr = 1'b0; ld = 4'b0000;
    n_checks++; if (obs !== 16'h5555) begin n_fail++; $display("FAIL clear_over_load: got %h want %h", obs, 16'h5555); end
    set_in(16'h1234); ld = 4'b1111;
    tick();
    ld = 4'b0000;
    n_checks++; if (obs !== 16'h1234) begin n_fail++; $display("FAIL reload: got %h want %h", obs, 16'h1234); end
  endtask

`ifdef DFF_BANK_SHIFT_EN
  task automatic test_shift();
    sh_start = 1'b1; sh_cnt = 3'd2; sh_in = 4'h9;
    tick();
    sh_start = 1'b0;
    n_checks++; if (obs !== 16'h1234) begin n_fail++; $display("FAIL shift_start_nomove: got %h want %h", obs, 16'h1234); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL shift_busy1: got %b want 1", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL shift_done1: got %b want 0", done); end
    tick();
    n_checks++; if (obs !== 16'h9123) begin n_fail++; $display("FAIL shift_step1: got %h want %h", obs, 16'h9123); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL shift_busy2: got %b want 1", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL shift_done2: got %b want 0", done); end
    tick();
    n_checks++; if (obs !== 16'h9912) begin n_fail++; $display("FAIL shift_step2: got %h want %h", obs, 16'h9912); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL shift_busy_end: got %b want 0", busy); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL shift_done_pulse: got %b want 1", done); end
  endtask

  task automatic test_back_to_back();
    // start accepted in the done cycle; load during busy is ignored
    sh_start = 1'b1; sh_cnt = 3'd1; sh_in = 4'h7;
    tick();
    sh_start = 1'b0; set_in(16'h0000); ld = 4'b1111;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_low: got %b want 0", done); end
    n_checks++; if (obs !== 16'h9912) begin n_fail++; $display("FAIL b2b_nomove: got %h want %h", obs, 16'h9912); end
    tick();
    ld = 4'b0000;
    n_checks++; if (obs !== 16'h7991) begin n_fail++; $display("FAIL b2b_step_ld_ignored: got %h want %h", obs, 16'h7991); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b want 1", done); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_once: got %b want 0", done); end
    n_checks++; if (obs !== 16'h7991) begin n_fail++; $display("FAIL b2b_idle_hold: got %h want %h", obs, 16'h7991); end
  endtask

  task automatic test_clear_abort();
    sh_start = 1'b1; sh_cnt = 3'd3; sh_in = 4'h6;
    tick();
    sh_start = 1'b0;
    tick();
    n_checks++; if (obs !== 16'h6799) begin n_fail++; $display("FAIL abort_step1: got %h want %h", obs, 16'h6799); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++; if (obs !== 16'h5555) begin n_fail++; $display("FAIL abort_clear: got %h want %h", obs, 16'h5555); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_no_late_done: got %b want 0", done); end
    n_checks++; if (obs !== 16'h5555) begin n_fail++; $display("FAIL abort_stays_clear: got %h want %h", obs, 16'h5555); end
  endtask

  task automatic test_zero_count();
    set_in(16'h1234); ld = 4'b1111;
    tick();
    ld = 4'b0000;
    sh_start = 1'b1; sh_cnt = 3'd0; sh_in = 4'h9;
    tick();
    sh_start = 1'b0;
    n_checks++; if (obs !== 16'h1234) begin n_fail++; $display("FAIL zero_nomove: got %h want %h", obs, 16'h1234); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", done); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_once: got %b want 0", done); end
  endtask

  task automatic test_start_with_load();
    sh_start = 1'b1; sh_cnt = 3'd1; sh_in = 4'h8; set_in(16'hAAAA); ld = 4'b1111;
    tick();
    sh_start = 1'b0;
    n_checks++; if (obs !== 16'h1234) begin n_fail++; $display("FAIL startld_discard: got %h want %h", obs, 16'h1234); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL startld_busy: got %b want 1", busy); end
    tick();
    ld = 4'b0000;
    n_checks++; if (obs !== 16'h8123) begin n_fail++; $display("FAIL startld_step: got %h want %h", obs, 16'h8123); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL startld_done: got %b want 1", done); end
  endtask
`else
  task automatic test_shift_disabled();
    sh_start = 1'b1; sh_cnt = 3'd2; sh_in = 4'h9; ld = 4'b0000;
    tick();
    sh_start = 1'b0;
    n_checks++; if (obs !== 16'h1234) begin n_fail++; $display("FAIL dis_nomove: got %h want %h", obs, 16'h1234); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dis_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL dis_done: got %b want 0", done); end
    tick();
    tick();
    n_checks++; if (obs !== 16'h1234) begin n_fail++; $display("FAIL dis_nomove_late: got %h want %h", obs, 16'h1234); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dis_busy_late: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL dis_done_late: got %b want 0", done); end
  endtask
`endif

  initial begin
    rst = 1'b0; clr = 1'b0; ld = '0; sh_start = 1'b0; sh_cnt = '0; sh_in = '0;
    set_in(16'h0000);
    tick();
    test_reset();
    test_load();
    test_clear_idle();
`ifdef DFF_BANK_SHIFT_EN
    test_shift();
    test_back_to_back();
    test_clear_abort();
    test_zero_count();
    test_start_with_load();
`else
    test_shift_disabled();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dff_bank_n_m.md
# dff_bank_n_m

Parametrised bank of M+1 registers, each N bits wide, every entry resetting to a common constant. It extends the plain reset-to-value register array with per-entry masked load, a synchronous clear command, and a multi-cycle shift (delay-line) mode driven by a small state machine with busy/done status. Used as a configuration/coefficient store and as a programmable-length delay line in datapath blocks.

## Interface
- N, 4, entry width in bits
- M, 15, index of last entry (bank holds entries 0..M, i.e. M+1 entries)
- RST_VAL, 0, value loaded into every entry on reset or clear (truncated to N bits)
- SHW, $clog2(M+2), width of shift-count input
- clk_i  input  1  clock; all state changes on rising edge
- rst_i  input  1  reset, synchronous and active-high
- in_i  input  N x [0:M]  parallel load data, one word per entry
- ld_i  input  M+1  per-entry load mask; bit k enables entry k
- clr_i  input  1  synchronous clear command
- sh_start_i  input  1  start a shift sequence
- sh_cnt_i  input  SHW  number of shift steps, sampled with sh_start_i
- sh_in_i  input  N  word shifted into entry 0 on each shift step
- out_o  output  N x [0:M]  registered bank contents
- busy_o  output  1  high while in SHIFT state
- done_o  output  1  one-cycle pulse at end of a shift sequence

## Operation
- Priority per cycle: rst_i > clr_i > active shift step > sh_start_i > load.
- Reset: all out_o entries = RST_VAL, state IDLE, counter 0, busy_o = 0, done_o = 0.
- Clear (clr_i=1): all entries = RST_VAL, state -> IDLE, counter 0, done_o = 0; aborts any shift in progress without a done pulse.
- Load (IDLE, no clr, no sh_start): entry k <= in_i[k] where ld_i[k]=1; others hold. ld_i=0 means hold all.
- States: IDLE, SHIFT.
  - IDLE -> SHIFT: sh_start_i=1 and sh_cnt_i != 0; counter <= sh_cnt_i; no data moves that cycle; ld_i ignored that cycle.
  - sh_start_i=1 with sh_cnt_i=0: stay IDLE, no data change, done_o pulses next cycle.
  - SHIFT: each cycle out[k] <= out[k-1] for k=1..M, out[0] <= sh_in_i (sampled that cycle); counter decrements; when counter reaches 1 the final step happens and state -> IDLE, done_o = 1 next cycle.
  - In SHIFT, ld_i and sh_start_i are ignored.
- Counts larger than M+1 are legal: extra steps keep shifting sh_in_i through; no saturation or error.
- Counter is SHW bits, unsigned; no wrap since it only decrements from a nonzero value to 0.

## Timing
- Load: out_o reflects in_i one cycle after ld_i asserted.
- Clear/reset: out_o = RST_VAL on the cycle after assertion.
- Shift of count C started at edge t: busy_o high from t+1 through t+C; shift steps at edges t+1..t+C; done_o high for exactly the cycle after edge t+C; busy_o low at that cycle.
- Back-to-back: sh_start_i is accepted on the cycle done_o is high (IDLE).
- All outputs registered; no combinational input-to-output paths.

## Configuration
- DFF_BANK_SHIFT_EN defined: SHIFT state, counter, busy_o/done_o logic compiled in as above.
- Undefined: no state machine or counter; sh_start_i, sh_cnt_i, sh_in_i ignored; busy_o and done_o tied 0; load, clear and reset unchanged.

## Structure
- Package dff_bank_pkg: state enum typedef (IDLE, SHIFT) and the per-entry operation enum (HOLD, LOAD, SHIFT, CLEAR).
- Sub-module dff_bank_lane: one N-bit entry selecting among hold / in_i[k] / left neighbour / RST_VAL from the operation code; the top instantiates M+1 lanes plus the controller.

## Test plan
- Reset with RST_VAL=5, N=4, M=3 -> all four entries 5, busy_o=0, done_o=0.
- ld_i=4'b0101, in_i={1,2,3,4} (entries 0..3) -> entries {1,5,3,5} after one cycle.
- From {1,2,3,4}, sh_start_i with sh_cnt_i=2, sh_in_i=9 -> after 2 steps {9,9,1,2}; busy_o high 2 cycles, then done_o one-cycle pulse.
- clr_i asserted during the second step of a 3-step shift -> all entries RST_VAL next cycle, busy_o=0, no done_o pulse.
- sh_start_i with ld_i=all-ones in the same IDLE cycle -> load discarded, shift proceeds; ld_i during busy_o ignored.
- sh_cnt_i=0 -> no data change, busy_o stays 0, done_o pulses once; with DFF_BANK_SHIFT_EN undefined, sh_start_i with sh_cnt_i=2 -> no data change, busy_o=done_o=0.
